// File: rtl/rs485_port_ctrl.sv
// rs485_port_ctrl: runtime mode control for a bank of RS-485 half-duplex
// transceivers. Each channel is off, tx-only, rx-only or half-duplex with
// driver-enable guard times around every transmission.
module rs485_port_ctrl #(
  parameter int                  CH_NUM    = 22,
  parameter int                  PRE_CYC   = 4,
  parameter int                  POST_CYC  = 4,
  parameter logic [2*CH_NUM-1:0] MODE_INIT = {2*CH_NUM{1'b0}},
  localparam int                 CHW       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cfg_wr,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CH_NUM-1:0] tx_en,
  input  logic [CH_NUM-1:0] tx_d,
  output logic [CH_NUM-1:0] tx_rdy,
  output logic [CH_NUM-1:0] rx_q,
  output logic [CH_NUM-1:0] busy,
  input  logic [CH_NUM-1:0] pad_r,
  output logic [CH_NUM-1:0] pad_d,
  output logic [CH_NUM-1:0] pad_de,
  output logic [CH_NUM-1:0] pad_nre
);

  // The guard counter only has to hold the larger of the two guard lengths minus one.
  localparam int CNT_MAX = (PRE_CYC > POST_CYC) ? PRE_CYC : POST_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] PRE_LOAD  = CW'(PRE_CYC - 1);
  localparam logic [CW-1:0] POST_LOAD = CW'(POST_CYC - 1);

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_TX  = 2'b01;
  localparam logic [1:0] MODE_RX  = 2'b10;
  localparam logic [1:0] MODE_HD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    TX   = 2'd2,
    POST = 2'd3
  } state_t;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    mode;
    logic [1:0]    pend_mode;
    logic          pend_valid;
    logic          sync_ff;
    logic          cfg_hit;
    logic          hd_start;
    logic          post_done;
    logic          de_nxt;
    logic          nre_nxt;
    logic          d_nxt;
    logic          rdy_nxt;
    logic          busy_nxt;
    logic          de_q;
    logic          nre_q;
    logic          d_q;
    logic          rdy_q;
    logic          busy_q;
    logic          rx_qq;

    assign cfg_hit   = cfg_wr && (cfg_ch == CHW'(i));
    assign hd_start  = (state == IDLE) && (mode == MODE_HD) && tx_en[i];
    assign post_done = (state == POST) && (cnt == '0);

    // Pin values for the next cycle, decoded from the current mode and sequencer state.
    always_comb begin
      de_nxt   = 1'b0;
      nre_nxt  = 1'b1;
      d_nxt    = 1'b0;
      rdy_nxt  = 1'b0;
      busy_nxt = 1'b0;
      unique case (mode)
        MODE_OFF: begin
        end
        MODE_TX: begin
          de_nxt  = 1'b1;
          d_nxt   = tx_d[i];
          rdy_nxt = 1'b1;
        end
        MODE_RX: begin
          nre_nxt = 1'b0;
        end
        default: begin
          unique case (state)
            IDLE: begin
              nre_nxt = 1'b0;
            end
            TX: begin
              de_nxt   = 1'b1;
              d_nxt    = tx_d[i];
              rdy_nxt  = 1'b1;
              busy_nxt = 1'b1;
            end
            default: begin
              de_nxt   = 1'b1;
              d_nxt    = 1'b1;
              busy_nxt = 1'b1;
            end
          endcase
        end
      endcase
    end

    // Direction sequencer, mode/pending-mode bookkeeping, receive synchroniser and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        state      <= IDLE;
        cnt        <= '0;
        mode       <= MODE_INIT[2*i +: 2];
        pend_mode  <= MODE_INIT[2*i +: 2];
        pend_valid <= 1'b0;
        sync_ff    <= 1'b1;
        rx_qq      <= 1'b1;
        de_q       <= 1'b0;
        nre_q      <= 1'b1;
        d_q        <= 1'b0;
        rdy_q      <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        de_q    <= de_nxt;
        nre_q   <= nre_nxt;
        d_q     <= d_nxt;
        rdy_q   <= rdy_nxt;
        busy_q  <= busy_nxt;
        sync_ff <= pad_r[i];
        rx_qq   <= nre_nxt ? 1'b1 : sync_ff;

        unique case (state)
          IDLE: begin
            if (hd_start) begin
              state <= PRE;
              cnt   <= PRE_LOAD;
            end
          end
          PRE: begin
            if (cnt == '0) begin
              state <= TX;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          TX: begin
            if (!tx_en[i]) begin
              state <= POST;
              cnt   <= POST_LOAD;
            end
          end
          POST: begin
            if (cnt == '0) begin
              state <= IDLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        endcase

        if (post_done) begin
          if (cfg_hit) begin
            mode <= cfg_mode;
          end else if (pend_valid) begin
            mode <= pend_mode;
          end
          pend_valid <= 1'b0;
        end else if (cfg_hit) begin
          if ((state == IDLE) && !hd_start) begin
            mode <= cfg_mode;
          end else begin
            pend_mode  <= cfg_mode;
            pend_valid <= 1'b1;
          end
        end
      end
    end

    assign pad_de[i]  = de_q;
    assign pad_nre[i] = nre_q;
    assign pad_d[i]   = d_q;
    assign tx_rdy[i]  = rdy_q;
    assign busy[i]    = busy_q;
    assign rx_q[i]    = rx_qq;
  end

endmodule

// File: tb/tb_rs485_port_ctrl.sv
// tb_rs485_port_ctrl: scoreboard bench for rs485_port_ctrl with four channels
// (off / tx-only / rx-only / half-duplex) plus a five-channel instance used
// for out-of-range configuration writes.
module tb_rs485_port_ctrl;

  localparam int         CH   = 4;
  localparam int         PRE  = 4;
  localparam int         POST = 4;
  localparam logic [7:0] INIT = 8'b11_10_01_00;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_ch = 2'd0;
  logic [1:0] cfg_mode = 2'd0;
  logic [3:0] tx_en = '0;
  logic [3:0] tx_d = '0;
  logic [3:0] pad_r = '1;
  logic [3:0] tx_rdy, rx_q, busy, pad_d, pad_de, pad_nre;

  logic       aux_cfg_wr = 1'b0;
  logic [2:0] aux_cfg_ch = 3'd0;
  logic [1:0] aux_cfg_mode = 2'd0;
  logic [4:0] aux_tx_en = '0;
  logic [4:0] aux_tx_d = '0;
  logic [4:0] aux_pad_r = '1;
  logic [4:0] aux_tx_rdy, aux_rx_q, aux_busy, aux_pad_d, aux_pad_de, aux_pad_nre;

  typedef struct {
    int         edge_n;
    logic [3:0] de;
    logic [3:0] nre;
    logic [3:0] d;
    logic [3:0] rdy;
    logic [3:0] busy;
    logic [3:0] rxq;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] r_hist[0:63];
  logic [1:0] exp_mode[4];

  int         n_cmp = 0;
  int         n_err = 0;

  int         sc_rise, sc_fall, sc_len, sc_late, sc_rst, sc_wr_a, sc_wr_b;
  logic       sc_off;
  logic [1:0] sc_mode_a, sc_mode_b;

  rs485_port_ctrl #(
    .CH_NUM(CH), .PRE_CYC(PRE), .POST_CYC(POST), .MODE_INIT(INIT)
  ) dut (
    .clk(clk), .n_rst(n_rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .tx_en(tx_en), .tx_d(tx_d), .tx_rdy(tx_rdy), .rx_q(rx_q), .busy(busy),
    .pad_r(pad_r), .pad_d(pad_d), .pad_de(pad_de), .pad_nre(pad_nre)
  );

  rs485_port_ctrl #(
    .CH_NUM(5), .PRE_CYC(PRE), .POST_CYC(POST), .MODE_INIT(10'b01_01_01_01_01)
  ) aux (
    .clk(clk), .n_rst(n_rst), .cfg_wr(aux_cfg_wr), .cfg_ch(aux_cfg_ch), .cfg_mode(aux_cfg_mode),
    .tx_en(aux_tx_en), .tx_d(aux_tx_d), .tx_rdy(aux_tx_rdy), .rx_q(aux_rx_q), .busy(aux_busy),
    .pad_r(aux_pad_r), .pad_d(aux_pad_d), .pad_de(aux_pad_de), .pad_nre(aux_pad_nre)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // {de, nre, d, rdy, busy, rxq} for a channel sitting statically in mode m.
  function automatic logic [5:0] mode_exp(input logic [1:0] m, input logic txd, input logic rprev);
    case (m)
      2'b00:   return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      2'b01:   return {1'b1, 1'b1, txd,  1'b1, 1'b0, 1'b1};
      2'b10:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rprev};
      default: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rprev};
    endcase
  endfunction

  // Channel 3 timeline of a half-duplex burst: PRE guard, TX, POST guard, then idle.
  function automatic logic [5:0] hd_exp(input int n, input logic txd, input logic rprev);
    int tx_start, tx_end, post_end;
    if (sc_rise == 0) return mode_exp(exp_mode[3], txd, rprev);
    tx_start = sc_rise + PRE + 1;
    tx_end   = (sc_fall > tx_start) ? sc_fall : tx_start;
    post_end = tx_end + POST;
    if (sc_off && n > post_end) return mode_exp(2'b00, txd, rprev);
    if (n >= sc_rise + 1 && n < tx_start) return {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    if (n >= tx_start && n <= tx_end)     return {1'b1, 1'b1, txd,  1'b1, 1'b1, 1'b1};
    if (n > tx_end && n <= post_end)      return {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rprev};
  endfunction

  task automatic set_scenario(input int rise, input int fall, input int len);
    sc_rise   = rise;
    sc_fall   = fall;
    sc_len    = len;
    sc_late   = 0;
    sc_rst    = 0;
    sc_wr_a   = 0;
    sc_wr_b   = 0;
    sc_off    = 1'b0;
    sc_mode_a = 2'b00;
    sc_mode_b = 2'b00;
  endtask

  task automatic applyStimulus(input int n);
    exp_t       e;
    logic [5:0] v;
    tx_en[2:0] = 3'($urandom);
    tx_en[3]   = ((n >= sc_rise) && (n < sc_fall)) ||
                 ((sc_late > 0) && (n >= sc_late) && (n < sc_late + 4));
    tx_d       = 4'($urandom);
    pad_r      = 4'($urandom);
    r_hist[n]  = pad_r;
    cfg_wr     = (n == sc_wr_a) || (n == sc_wr_b);
    cfg_ch     = 2'd3;
    cfg_mode   = (n == sc_wr_b) ? sc_mode_b : sc_mode_a;
    e.edge_n   = n;
    for (int c = 0; c < CH; c++) begin
      if (c == 3) v = hd_exp(n, tx_d[3], r_hist[n-1][3]);
      else        v = mode_exp(exp_mode[c], tx_d[c], r_hist[n-1][c]);
      {e.de[c], e.nre[c], e.d[c], e.rdy[c], e.busy[c], e.rxq[c]} = v;
    end
    sb_q.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t  e;
    string t;
    checkOutput("sb_depth", 5'(sb_q.size()), 5'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    t = $sformatf("e%0d", e.edge_n);
    checkOutput({t, ".de"},   {1'b0, pad_de},  {1'b0, e.de});
    checkOutput({t, ".nre"},  {1'b0, pad_nre}, {1'b0, e.nre});
    checkOutput({t, ".d"},    {1'b0, pad_d},   {1'b0, e.d});
    checkOutput({t, ".rdy"},  {1'b0, tx_rdy},  {1'b0, e.rdy});
    checkOutput({t, ".busy"}, {1'b0, busy},    {1'b0, e.busy});
    checkOutput({t, ".rxq"},  {1'b0, rx_q},    {1'b0, e.rxq});
  endtask

  task automatic push_reset_exp(input int tag_n);
    exp_t e;
    e.edge_n = tag_n;
    e.de     = 4'b0000;
    e.nre    = 4'b1111;
    e.d      = 4'b0000;
    e.rdy    = 4'b0000;
    e.busy   = 4'b0000;
    e.rxq    = 4'b1111;
    sb_q.push_back(e);
  endtask

  task automatic run_window();
    r_hist[0] = pad_r;
    for (int n = 1; n <= sc_len; n++) begin
      @(negedge clk);
      applyStimulus(n);
      @(posedge clk);
      #1;
      compare_pop();
      if (n == sc_rst) begin
        #1;
        n_rst = 1'b0;
        #1;
        push_reset_exp(1000 + n);
        compare_pop();
        break;
      end
    end
    @(negedge clk);
    cfg_wr = 1'b0;
    tx_en  = '0;
  endtask

  task automatic set_mode(input logic [1:0] ch, input logic [1:0] m);
    @(negedge clk);
    tx_en    = '0;
    cfg_wr   = 1'b1;
    cfg_ch   = ch;
    cfg_mode = m;
    @(negedge clk);
    cfg_wr = 1'b0;
    repeat (3) @(negedge clk);
    exp_mode[ch] = m;
  endtask

  task automatic aux_write(input logic [2:0] ch);
    @(negedge clk);
    aux_cfg_wr   = 1'b1;
    aux_cfg_ch   = ch;
    aux_cfg_mode = 2'b00;
    @(negedge clk);
    aux_cfg_wr = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < CH; c++) exp_mode[c] = INIT[2*c +: 2];

    #12;
    push_reset_exp(0);
    compare_pop();
    checkOutput("aux_rst_de", aux_pad_de, 5'b00000);
    @(negedge clk);
    n_rst = 1'b1;

    $display("[TB] long burst with static channels");
    set_scenario(10, 20, 28);
    run_window();

    $display("[TB] one-cycle tx_en pulse");
    set_scenario(10, 11, 24);
    run_window();

    $display("[TB] tx_en dropped during PRE");
    set_scenario(10, 12, 24);
    run_window();

    $display("[TB] mode writes during a burst");
    set_scenario(10, 20, 36);
    sc_wr_a   = 15;
    sc_mode_a = 2'b01;
    sc_wr_b   = 17;
    sc_mode_b = 2'b00;
    sc_off    = 1'b1;
    sc_late   = 28;
    run_window();
    exp_mode[3] = 2'b00;

    $display("[TB] out-of-range channel writes");
    @(posedge clk);
    #1;
    checkOutput("aux_de_init", aux_pad_de, 5'b11111);
    aux_write(3'd5);
    aux_write(3'd6);
    aux_write(3'd7);
    @(posedge clk);
    #1;
    checkOutput("aux_de_oor", aux_pad_de, 5'b11111);
    checkOutput("aux_nre_oor", aux_pad_nre, 5'b11111);
    aux_write(3'd4);
    @(posedge clk);
    #1;
    checkOutput("aux_de_ch4", aux_pad_de, 5'b01111);
    checkOutput("aux_rdy_ch4", aux_tx_rdy, 5'b01111);

    $display("[TB] reset during TX");
    set_mode(2'd3, 2'b11);
    set_mode(2'd0, 2'b01);
    set_scenario(10, 25, 30);
    sc_rst = 17;
    run_window();
    for (int c = 0; c < CH; c++) exp_mode[c] = INIT[2*c +: 2];
    pad_r = '1;
    @(negedge clk);
    n_rst = 1'b1;
    set_scenario(0, 0, 8);
    run_window();
    checkOutput("aux_de_after_rst", aux_pad_de, 5'b11111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rs485_port_ctrl.md
Name: rs485_port_ctrl

Overview:
- Parametrised controller for a bank of RS-485 half-duplex transceivers (R, D, nRE, DE pad sets), one instance per board.
- Replaces fixed per-transceiver tie-offs with a runtime mode per channel: off, tx-only, rx-only or half-duplex auto-direction.
- In half-duplex mode it applies driver-enable guard times around each transmission.
- Sits between the HSI master/slave line signals (com/dat) and the transceiver pins.

Parameters:
- CH_NUM, 22, number of transceiver channels (1..32)
- PRE_CYC, 4, clk cycles DE is held with D=1 before the user may transmit (>=1)
- POST_CYC, 4, clk cycles DE is held with D=1 after tx_en falls (>=1)
- MODE_INIT, {2*CH_NUM{1'b0}}, reset mode per channel, 2 bits each, channel i at [2i+1:2i]

Ports:
- clk  in  1  system clock (CLK_48 domain)
- n_rst  in  1  asynchronous active-low reset
- cfg_wr  in  1  one-cycle strobe, write cfg_mode to channel cfg_ch
- cfg_ch  in  CHW=max(1,$clog2(CH_NUM))  target channel
- cfg_mode  in  2  00 off, 01 tx-only, 10 rx-only, 11 half-duplex
- tx_en  in  CH_NUM  per-channel transmit request (level)
- tx_d  in  CH_NUM  per-channel line data from HSI logic
- tx_rdy  out  CH_NUM  driver settled; tx_d is passed to pad
- rx_q  out  CH_NUM  synchronised receive data
- busy  out  CH_NUM  channel in PRE/TX/POST
- pad_r  in  CH_NUM  transceiver R pins
- pad_d  out  CH_NUM  transceiver D pins
- pad_de  out  CH_NUM  transceiver DE pins
- pad_nre  out  CH_NUM  transceiver nRE pins

Behaviour:
- Reset: mode[i]=MODE_INIT[i], state=IDLE. All outputs registered. Reset values: pad_de=0, pad_nre=1, pad_d=0, tx_rdy=0, busy=0, rx_q=1, sync flops=1.
- Per-channel state machine: IDLE, PRE, TX, POST, with down-counter cnt sized for max(PRE_CYC,POST_CYC).
- Mode 00 (off): de=0, nre=1, d=0, tx_rdy=0; tx_en is ignored.
- Mode 01 (tx-only): de=1, nre=1, tx_rdy=1, d=tx_d (1-cycle registered); there is no state sequencing.
- Mode 10 (rx-only): de=0, nre=0, d=0, tx_rdy=0; tx_en is ignored.
- Mode 11, IDLE: de=0, nre=0. On tx_en=1 at edge k: enter PRE with cnt=PRE_CYC-1; at k+1 de=1, nre=1, d=1, busy=1.
- Mode 11, PRE: decrement cnt; at cnt==0 go to TX. tx_rdy=1 and d=tx_d from edge k+1+PRE_CYC.
- Mode 11, TX: d follows tx_d with one-cycle latency. When tx_en=0 is sampled, go to POST with cnt=POST_CYC-1; tx_rdy=0 and d=1 next cycle; de stays 1.
- Mode 11, POST: on cnt==0 go to IDLE, giving de=0 and nre=0 next cycle; busy drops in the same cycle. tx_en is ignored during POST. A tx_en still high in IDLE starts a new PRE on the following edge.
- tx_en dropped during PRE: PRE completes, TX is held for exactly 1 cycle (tx_rdy pulse), then POST. The guard pair is never shortened.
- rx_q: 2-FF synchroniser on pad_r, gated by the nre state.
  - When nre=1, rx_q=1 (line idle mark), forced in the same cycle nre rises.
  - When nre=0, rx_q is the synchroniser output, 2 cycles after pad_r.
- Config write:
  - cfg_wr with cfg_ch>=CH_NUM is ignored.
  - If the target is in IDLE, or in mode 00/01/10, the new mode takes effect from the next edge.
  - If the target is in PRE/TX/POST, the mode is stored as pending and applied on the cycle the channel returns to IDLE. A later write overwrites the pending mode.
  - Leaving mode 11 while busy always completes POST first.
- Channels are fully independent. Simultaneous cfg_wr and tx_en on the same channel: tx_en is evaluated under the old mode and cfg_wr follows the pending rule.
- Async reset mid-TX immediately forces reset pad values; no POST is performed.

Test Plan (CH_NUM=4, PRE_CYC=4, POST_CYC=4):
- Reset with MODE_INIT=8'b11_10_01_00 -> ch0 de=0/nre=1/d=0; ch1 de=1, d=tx_d[1]+1cyc; ch2 nre=0, rx_q=pad_r delayed 2; ch3 idle nre=0, de=0.
- ch3 tx_en rises at edge 10, falls at edge 20 -> de=1 at 11..24, tx_rdy=1 at 15..20, d=1 at 11..14 and 21..24, de=0/nre=0 at 25, busy=1 at 11..24.
- ch3 tx_en 1-cycle pulse at edge 10 -> PRE 11..14, tx_rdy=1 only at 15, POST 16..19, idle at 20.
- cfg_wr ch3 mode 00 at edge 17 of a TX burst -> burst and POST complete unchanged; at IDLE entry ch3 goes off (nre=1, de=0); later tx_en ignored.
- cfg_wr with cfg_ch=5 -> no mode change on any channel. Toggle pad_r[3] while ch3 in TX -> rx_q[3] stays 1.
- Assert n_rst low during ch3 TX -> de=0, nre=1, tx_rdy=0 immediately. After release -> modes return to MODE_INIT.
